// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-split helpers for the data cache.
// No logic; the helpers take field widths so they also serve non-default builds.
// No flow control.
package dcache_pkg;
    localparam int DEF_LINES      = 32;
    localparam int DEF_LINE_WORDS = 8;
    localparam int WORD_W         = $clog2(DEF_LINE_WORDS);
    localparam int OFFSET_W       = WORD_W + 2;
    localparam int INDEX_W        = $clog2(DEF_LINES);
    localparam int TAG_W          = 32 - INDEX_W - OFFSET_W;
    localparam int LINE_BITS      = DEF_LINE_WORDS * 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_e;

    function automatic logic [31:0] addr_word(input logic [31:0] addr, input int word_w);
        return (addr >> 2) & ((32'd1 << word_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int offset_w,
                                               input int index_w);
        return (addr >> offset_w) & ((32'd1 << index_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int offset_w,
                                             input int index_w);
        return addr >> (offset_w + index_w);
    endfunction
endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for a direct-mapped cache, one line per index.
// Combinational read; single write port (whole-line fill or single-word store).
// No backpressure; a write lands on the next clock edge.
module dcache_array #(
    parameter int LINES      = 32,
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = 5,
    parameter int TAG_W      = 22,
    parameter int WRD_W      = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [IDX_W-1:0]           idx_i,
    output logic                       rd_vld_o,
    output logic                       rd_dirty_o,
    output logic [TAG_W-1:0]           rd_tag_o,
    output logic [LINE_WORDS*32-1:0]   rd_line_o,
    input  logic                       wr_en_i,
    input  logic                       wr_line_i,
    input  logic [WRD_W-1:0]           wr_word_i,
    input  logic [TAG_W-1:0]           wr_tag_i,
    input  logic [LINE_WORDS*32-1:0]   wr_line_dat_i,
    input  logic [31:0]                wr_word_dat_i
);
    localparam int LB = LINE_WORDS * 32;

    logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [TAG_W-1:0] tag_d [LINES];
    logic [LB-1:0]    data_q [LINES];
    logic [LB-1:0]    data_d [LINES];

    assign rd_vld_o   = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_line_o  = data_q[idx_i];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en_i) begin
            if (wr_line_i) begin
                tag_d[idx_i]   = wr_tag_i;
                data_d[idx_i]  = wr_line_dat_i;
                valid_d[idx_i] = 1'b1;
                dirty_d[idx_i] = 1'b0;
            end else begin
                data_d[idx_i][32*int'(wr_word_i) +: 32] = wr_word_dat_i;
                dirty_d[idx_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data contents survive reset; only the valid bits gate their use.
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller; DCACHE_STATS_EN adds hit/miss counters.
// Hits: 0 extra cycles. Misses: stall through optional line write-back plus line refill.
// stall_o = req_i && !hit freezes the pipeline; memory request held until mem_ack_i.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [31:0]               addr_i,
    input  logic [31:0]               wdata_i,
    output logic [31:0]               rdata_o,
    output logic                      stall_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [31:0]               mem_addr_o,
    output logic [LINE_WORDS*32-1:0]  mem_wdata_o,
    input  logic                      mem_ack_i,
    input  logic [LINE_WORDS*32-1:0]  mem_rdata_i,
    output logic [31:0]               hit_cnt_o,
    output logic [31:0]               miss_cnt_o
);
    localparam int LW_W   = $clog2(LINE_WORDS);
    localparam int LOFF_W = LW_W + 2;
    localparam int LIDX_W = $clog2(LINES);
    localparam int LTAG_W = 32 - LIDX_W - LOFF_W;
    localparam int LB     = LINE_WORDS * 32;

    state_e              state_q, state_d;
    logic [LIDX_W-1:0]   idx;
    logic [LTAG_W-1:0]   tag;
    logic [LW_W-1:0]     word;
    logic                rd_vld, rd_dirty, hit;
    logic [LTAG_W-1:0]   rd_tag;
    logic [LB-1:0]       rd_line;
    logic                wr_en, wr_line;

    assign idx  = LIDX_W'(addr_index(addr_i, LOFF_W, LIDX_W));
    assign tag  = LTAG_W'(addr_tag(addr_i, LOFF_W, LIDX_W));
    assign word = LW_W'(addr_word(addr_i, LW_W));

    dcache_array #(
        .LINES(LINES), .LINE_WORDS(LINE_WORDS),
        .IDX_W(LIDX_W), .TAG_W(LTAG_W), .WRD_W(LW_W)
    ) u_array (
        .clk_i(clk_i), .rst_i(rst_i), .idx_i(idx),
        .rd_vld_o(rd_vld), .rd_dirty_o(rd_dirty), .rd_tag_o(rd_tag), .rd_line_o(rd_line),
        .wr_en_i(wr_en), .wr_line_i(wr_line), .wr_word_i(word), .wr_tag_i(tag),
        .wr_line_dat_i(mem_rdata_i), .wr_word_dat_i(wdata_i)
    );

    assign hit     = req_i && rd_vld && (rd_tag == tag);
    assign stall_o = req_i && !hit;
    assign rdata_o = hit ? rd_line[32*int'(word) +: 32] : 32'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (stall_o) state_d = (rd_vld && rd_dirty) ? WB : FILL;
            WB:      if (mem_ack_i) state_d = FILL;
            FILL:    if (mem_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The index comes from the held request address, so the array read port shows the victim during WB.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = '0;
        wr_en       = 1'b0;
        wr_line     = 1'b0;
        case (state_q)
            IDLE: wr_en = hit && we_i;
            WB: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {rd_tag, idx, LOFF_W'(0)};
                mem_wdata_o = rd_line;
            end
            FILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {tag, idx, LOFF_W'(0)};
                wr_en      = mem_ack_i;
                wr_line    = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + 32'(hit && !stall_o);
        miss_cnt_d = miss_cnt_q + 32'((state_q == IDLE) && (state_d != IDLE));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: access vector table, scoreboarded memory transactions and load data,
// plus hand-written reset-during-fill and spurious-ack sequences.
module tb_dcache_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1, req = 1'b0, we = 1'b0;
    logic [31:0]  addr = 32'd0, wdata = 32'd0, rdata;
    logic         stall, mem_req, mem_we;
    logic [31:0]  mem_addr, hit_cnt, miss_cnt;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .stall_o(stall), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model with a transaction scoreboard.
    typedef struct {logic we; logic [31:0] addr; logic chk_w1; logic [31:0] w1;} memx_t;
    memx_t        exp_mem_q[$];
    logic [255:0] mem_store [logic [31:0]];
    int           mem_lat = 4, mem_cnt = 0;
    logic         spur = 1'b0;

    function automatic logic [31:0] pat(input logic [31:0] la, input int w);
        return 32'hA500_0000 + la + 32'(w);
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem_store.exists(la)) return mem_store[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat(la, w);
        return l;
    endfunction

    always @(negedge clk) begin
        memx_t e;
        mem_ack = 1'b0;
        if (spur) begin
            mem_ack   = 1'b1;
            mem_rdata = '1;
            spur      = 1'b0;
        end else if (mem_req) begin
            if (mem_cnt == 0) begin
                if (exp_mem_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL mem_unexpected_req: got we=%0d addr=%h expected none", mem_we, mem_addr);
                end else begin
                    e = exp_mem_q.pop_front();
                    check("mem_we", 32'(mem_we), 32'(e.we));
                    check("mem_addr", mem_addr, e.addr);
                    if (e.chk_w1) check("wb_word1", mem_wdata[63:32], e.w1);
                end
            end
            mem_cnt++;
            if (mem_cnt == mem_lat) begin
                mem_ack = 1'b1;
                if (mem_we) mem_store[mem_addr] = mem_wdata;
                else        mem_rdata = mem_line(mem_addr);
                mem_cnt = 0;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // The MEM stage must hold its request steady while stalled.
    logic        chk_stall = 1'b0;
    logic [65:0] chk_in = '0;
    always @(posedge clk) begin
        if (chk_stall && !rst)
            assert ({req, we, addr, wdata} == chk_in) else $error("MEM-stage inputs changed during stall");
        chk_stall <= stall && !rst;
        chk_in    <= {req, we, addr, wdata};
    end

    typedef struct {
        logic we; logic [31:0] addr; logic [31:0] wdata; int stall; logic [31:0] rdata;
        logic wb; logic [31:0] wb_addr; logic [31:0] wb_w1;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input int s, input logic [31:0] r, input logic wb,
                                input logic [31:0] wba, input logic [31:0] w1);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.stall = s; v.rdata = r;
        v.wb = wb; v.wb_addr = wba; v.wb_w1 = w1;
        return v;
    endfunction

    logic [31:0] rd_q[$];

    task automatic run_vec(input vec_t v, input string name);
        int st = 0;
        logic [31:0] e;
        if (v.wb) exp_mem_q.push_back('{1'b1, v.wb_addr, 1'b1, v.wb_w1});
        if (v.stall > 0) exp_mem_q.push_back('{1'b0, v.addr & ~32'h1F, 1'b0, 32'd0});
        if (!v.we) rd_q.push_back(v.rdata);
        @(negedge clk);
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
        #1;
        while (stall && st < 300) begin
            st++;
            @(negedge clk);
            #1;
        end
        if (stall) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: got stall still high expected release", name);
        end
        check({name, "_stall_cycles"}, 32'(st), 32'(v.stall));
        if (!v.we) begin
            e = rd_q.pop_front();
            check({name, "_rdata"}, rdata, e);
        end
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
    endtask

    vec_t vecs[11];
    int   exp_hits, exp_misses;

    initial begin
        vecs[0]  = mk(0, 32'h0040, 0, 5, pat(32'h40, 0), 0, 0, 0);
        vecs[1]  = mk(1, 32'h0044, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 32'h0044, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        vecs[3]  = mk(0, 32'h0048, 0, 0, pat(32'h40, 2), 0, 0, 0);
        vecs[4]  = mk(0, 32'h0444, 0, 9, pat(32'h440, 1), 1, 32'h0040, 32'hDEADBEEF);
        vecs[5]  = mk(0, 32'h0040, 0, 5, pat(32'h40, 0), 0, 0, 0);
        vecs[6]  = mk(0, 32'h0044, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        vecs[7]  = mk(1, 32'h1000, 32'h12345678, 5, 0, 0, 0, 0);
        vecs[8]  = mk(0, 32'h1000, 0, 0, 32'h12345678, 0, 0, 0);
        vecs[9]  = mk(0, 32'h101C, 0, 0, pat(32'h1000, 7), 0, 0, 0);
        vecs[10] = mk(0, 32'h0C00, 0, 9, pat(32'hC00, 0), 1, 32'h1000, pat(32'h1000, 1));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata_or", 32'(|mem_wdata), 0);
        check("rst_rdata", rdata, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);

        exp_hits = 0; exp_misses = 0;
        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            exp_hits++;
            if (vecs[i].stall > 0) exp_misses++;
        end
`ifdef DCACHE_STATS_EN
        check("hit_cnt", hit_cnt, 32'(exp_hits));
        check("miss_cnt", miss_cnt, 32'(exp_misses));
`else
        check("hit_cnt_tied", hit_cnt, 0);
        check("miss_cnt_tied", miss_cnt, 0);
`endif

        // Spurious ack in IDLE: no request, no array write.
        spur = 1'b1;
        @(negedge clk);
        #1;
        check("spur_mem_req", 32'(mem_req), 0);
        check("spur_stall", 32'(stall), 0);
        run_vec(mk(0, 32'h0044, 0, 0, 32'hDEADBEEF, 0, 0, 0), "spur_ld44");
        run_vec(mk(0, 32'h0C04, 0, 0, pat(32'hC00, 1), 0, 0, 0), "spur_ldc04");

        // Reset during FILL abandons the transfer and invalidates the cache.
        exp_mem_q.push_back('{1'b0, 32'h2040, 1'b0, 32'd0});
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h2040;
        @(negedge clk);
        #1;
        check("fill_mem_req", 32'(mem_req), 1);
        check("fill_stall", 32'(stall), 1);
        rst = 1'b1; req = 1'b0;
        @(posedge clk);
        #1;
        check("rstfill_mem_req", 32'(mem_req), 0);
        check("rstfill_stall", 32'(stall), 0);
        check("rstfill_hit_cnt", hit_cnt, 0);
        check("rstfill_miss_cnt", miss_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(0, 32'h2040, 0, 5, pat(32'h2040, 0), 0, 0, 0), "rst_reload");
`ifdef DCACHE_STATS_EN
        check("post_rst_hit_cnt", hit_cnt, 1);
        check("post_rst_miss_cnt", miss_cnt, 1);
`endif
        repeat (2) @(negedge clk);
        check("mem_q_left", 32'(exp_mem_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
